// File: rtl/scc_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scc_isa_pkg
// Description : Shared ISA definitions (opcodes, field positions, condition
//               codes) for the fetch and decode stages.
// Revision    : 1.0 - initial release
// ============================================================================
package scc_isa_pkg;

  // Instruction field bit positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 25;
  localparam int RD_LO  = 22;
  localparam int RS1_LO = 19;
  localparam int RS2_LO = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = 16;
  localparam int OP_W   = 7;

  // Opcodes that are not part of the two ALU classes
  localparam logic [6:0] OP_LOAD  = 7'b1000000;
  localparam logic [6:0] OP_STORE = 7'b1000001;
  localparam logic [6:0] OP_B     = 7'b1100000;
  localparam logic [6:0] OP_BCOND = 7'b1100001;
  localparam logic [6:0] OP_BR    = 7'b1100010;
  localparam logic [6:0] OP_NOP   = 7'b1100100;

  // Canonical NOP instruction word (OP_NOP with all other fields zero)
  localparam logic [31:0] NOP_WORD = 32'hC8000000;

  // Condition codes carried in the rd field of BCOND
  typedef enum logic [2:0] {
    CC_EQ = 3'b000,
    CC_NE = 3'b001,
    CC_CS = 3'b010,
    CC_CC = 3'b011,
    CC_MI = 3'b100,
    CC_PL = 3'b101,
    CC_VS = 3'b110,
    CC_AL = 3'b111
  } cond_e;

  // Bit positions of the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage : scc_isa_pkg
`default_nettype wire

// File: rtl/id_decoder.sv
`default_nettype none
// ============================================================================
// Module      : id_decoder
// Description : Purely combinational instruction decoder: opcode class to
//               control bits, register-use bits and sign-extended immediate.
// Revision    : 1.0 - initial release
// ============================================================================
module id_decoder
  import scc_isa_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  logic [DATA_W-1:0] instr,
  output logic [OP_W-1:0]   opcode,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [2:0]        cond,
  output logic              use_rs1,
  output logic              use_rs2,
  output logic              use_imm,
  output logic              reg_we,
  output logic              mem_re,
  output logic              mem_we,
  output logic              set_flags,
  output logic              is_bcond,
  output logic              valid,
  output logic [DATA_W-1:0] imm_ext
);

  logic [OP_W-1:0] op;

  // Raw field extraction; register addresses go straight to the register file
  assign op      = instr[OP_HI:OP_LO];
  assign rs1     = instr[RS1_LO +: REG_AW];
  assign rs2     = instr[RS2_LO +: REG_AW];
  assign cond    = instr[RD_LO +: 3];
  assign imm_ext = {{(DATA_W-IMM_W){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};

  // Opcode class decode; anything unrecognised (including B/BR) becomes a NOP
  always_comb begin
    opcode    = OP_NOP;
    rd        = '0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_imm   = 1'b0;
    reg_we    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    set_flags = 1'b0;
    is_bcond  = 1'b0;
    valid     = 1'b0;
    casez (op)
      7'b00?????: begin
        opcode    = op;
        rd        = instr[RD_LO +: REG_AW];
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        reg_we    = 1'b1;
        set_flags = op[4];
        valid     = 1'b1;
      end
      7'b01?????: begin
        opcode    = op;
        rd        = instr[RD_LO +: REG_AW];
        use_rs1   = 1'b1;
        use_imm   = 1'b1;
        reg_we    = 1'b1;
        set_flags = op[4];
        valid     = 1'b1;
      end
      OP_LOAD: begin
        opcode  = op;
        rd      = instr[RD_LO +: REG_AW];
        use_rs1 = 1'b1;
        use_imm = 1'b1;
        reg_we  = 1'b1;
        mem_re  = 1'b1;
        valid   = 1'b1;
      end
      OP_STORE: begin
        opcode  = op;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        mem_we  = 1'b1;
        valid   = 1'b1;
      end
      OP_BCOND: begin
        opcode   = op;
        use_imm  = 1'b1;
        is_bcond = 1'b1;
        valid    = 1'b1;
      end
      // Unconditional branches are resolved in fetch and retire here as NOPs
      OP_B, OP_BR, OP_NOP: begin
        opcode = OP_NOP;
      end
      default: begin
        opcode = OP_NOP;
      end
    endcase
  end

endmodule : id_decoder
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : Instruction decode stage: register-file addressing, load-use
//               and flag hazard detection, BCOND resolution and the
//               decode/execute pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage
  import scc_isa_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction_in,
  input  logic              stall_in,
  input  logic [3:0]        flags_in,
  input  logic [DATA_W-1:0] pc_in,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              hold_out,
  output logic              branch,
  output logic [DATA_W-1:0] cond_pc_val,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_opcode,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic              ex_reg_we,
  output logic              ex_mem_re,
  output logic              ex_mem_we,
  output logic              ex_set_flags
);

  localparam logic [OP_W-1:0] NOP_OP = NOP_WORD[OP_HI:OP_LO];

  logic [OP_W-1:0]   dec_opcode;
  logic [REG_AW-1:0] dec_rd;
  logic [2:0]        dec_cond;
  logic              dec_use_rs1;
  logic              dec_use_rs2;
  logic              dec_use_imm;
  logic              dec_reg_we;
  logic              dec_mem_re;
  logic              dec_mem_we;
  logic              dec_set_flags;
  logic              dec_is_bcond;
  logic              dec_valid;
  logic [DATA_W-1:0] dec_imm;

  logic              load_use_hz;
  logic              flag_hz;
  logic              hazard;
  logic              cond_true;
  logic [DATA_W-1:0] target_sum;
  logic [DATA_W-1:0] op_a_next;
  logic [DATA_W-1:0] op_b_next;

  id_decoder #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_decoder (
    .instr     (instruction_in),
    .opcode    (dec_opcode),
    .rd        (dec_rd),
    .rs1       (rs1_addr),
    .rs2       (rs2_addr),
    .cond      (dec_cond),
    .use_rs1   (dec_use_rs1),
    .use_rs2   (dec_use_rs2),
    .use_imm   (dec_use_imm),
    .reg_we    (dec_reg_we),
    .mem_re    (dec_mem_re),
    .mem_we    (dec_mem_we),
    .set_flags (dec_set_flags),
    .is_bcond  (dec_is_bcond),
    .valid     (dec_valid),
    .imm_ext   (dec_imm)
  );

  // A load in execute blocks any instruction that reads its destination;
  // only source fields the instruction class really uses are compared.
  assign load_use_hz = ex_valid && ex_mem_re &&
                       ((dec_use_rs1 && (ex_rd == rs1_addr)) ||
                        (dec_use_rs2 && (ex_rd == rs2_addr)));
  // BCOND must see the flags produced by a flag-setting op still in execute
  assign flag_hz     = dec_is_bcond && ex_valid && ex_set_flags;
  assign hazard      = load_use_hz || flag_hz;
  assign hold_out    = hazard || stall_in;

  // Evaluate the BCOND condition against the current flags
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(dec_cond))
      CC_EQ:   cond_true =  flags_in[FLAG_Z];
      CC_NE:   cond_true = !flags_in[FLAG_Z];
      CC_CS:   cond_true =  flags_in[FLAG_C];
      CC_CC:   cond_true = !flags_in[FLAG_C];
      CC_MI:   cond_true =  flags_in[FLAG_N];
      CC_PL:   cond_true = !flags_in[FLAG_N];
      CC_VS:   cond_true =  flags_in[FLAG_V];
      CC_AL:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Target is word aligned; the add wraps naturally at DATA_W bits
  assign target_sum  = pc_in + dec_imm;
  assign cond_pc_val = {target_sum[DATA_W-1:2], 2'b00};
  assign branch      = dec_is_bcond && cond_true && !hazard && !stall_in;

  // Operand selection; unused operands are zeroed so NOPs carry no stale data
  assign op_a_next = dec_use_rs1 ? rs1_data : '0;
  assign op_b_next = dec_use_imm ? dec_imm : (dec_use_rs2 ? rs2_data : '0);

  // Decode/execute pipeline register: stall holds, hazard bubbles, else load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= NOP_OP;
      ex_rd        <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_reg_we    <= 1'b0;
      ex_mem_re    <= 1'b0;
      ex_mem_we    <= 1'b0;
      ex_set_flags <= 1'b0;
    end else if (stall_in) begin
      ex_valid     <= ex_valid;
      ex_opcode    <= ex_opcode;
      ex_rd        <= ex_rd;
      ex_op_a      <= ex_op_a;
      ex_op_b      <= ex_op_b;
      ex_reg_we    <= ex_reg_we;
      ex_mem_re    <= ex_mem_re;
      ex_mem_we    <= ex_mem_we;
      ex_set_flags <= ex_set_flags;
    end else if (hazard) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= NOP_OP;
      ex_rd        <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_reg_we    <= 1'b0;
      ex_mem_re    <= 1'b0;
      ex_mem_we    <= 1'b0;
      ex_set_flags <= 1'b0;
    end else begin
      ex_valid     <= dec_valid;
      ex_opcode    <= dec_opcode;
      ex_rd        <= dec_rd;
      ex_op_a      <= op_a_next;
      ex_op_b      <= op_b_next;
      ex_reg_we    <= dec_reg_we;
      ex_mem_re    <= dec_mem_re;
      ex_mem_we    <= dec_mem_we;
      ex_set_flags <= dec_set_flags;
    end
  end

endmodule : id_stage
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Directed self-checking bench for id_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;
  import scc_isa_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] instruction_in;
  logic        stall_in;
  logic [3:0]  flags_in;
  logic [31:0] pc_in;
  logic [2:0]  rs1_addr;
  logic [2:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        hold_out;
  logic        branch;
  logic [31:0] cond_pc_val;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_rd;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic        ex_reg_we;
  logic        ex_mem_re;
  logic        ex_mem_we;
  logic        ex_set_flags;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage #(
    .DATA_W (32),
    .REG_AW (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instruction_in (instruction_in),
    .stall_in       (stall_in),
    .flags_in       (flags_in),
    .pc_in          (pc_in),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .hold_out       (hold_out),
    .branch         (branch),
    .cond_pc_val    (cond_pc_val),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_rd          (ex_rd),
    .ex_op_a        (ex_op_a),
    .ex_op_b        (ex_op_b),
    .ex_reg_we      (ex_reg_we),
    .ex_mem_re      (ex_mem_re),
    .ex_mem_we      (ex_mem_we),
    .ex_set_flags   (ex_set_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    instruction_in = NOP_WORD;
    stall_in       = 1'b0;
    flags_in       = 4'b0000;
    pc_in          = 32'h0;
    rs1_data       = 32'h0;
    rs2_data       = 32'h0;

    // ---------------- reset state ----------------
    #1 reset = 1'b0;
    #1;
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_opcode", {25'd0, ex_opcode}, 32'h64);
    check("rst_ex_rd", {29'd0, ex_rd}, 32'd0);
    check("rst_ex_op_a", ex_op_a, 32'd0);
    check("rst_ex_op_b", ex_op_b, 32'd0);
    check("rst_enables", {28'd0, ex_reg_we, ex_mem_re, ex_mem_we, ex_set_flags}, 32'd0);
    #21 reset = 1'b1;
    tick();

    // ---------------- ALU-imm with negative immediate ----------------
    instruction_in = mk(7'b0100000, 3'd3, 3'd2, 3'd0, 16'hFFFF);
    rs1_data = 32'd10;
    #1;
    check("aluimm_rs1_addr", {29'd0, rs1_addr}, 32'd2);
    check("aluimm_hold", {31'd0, hold_out}, 32'd0);
    tick();
    check("aluimm_valid", {31'd0, ex_valid}, 32'd1);
    check("aluimm_opcode", {25'd0, ex_opcode}, 32'h20);
    check("aluimm_rd", {29'd0, ex_rd}, 32'd3);
    check("aluimm_op_a", ex_op_a, 32'd10);
    check("aluimm_op_b", ex_op_b, 32'hFFFFFFFF);
    check("aluimm_reg_we", {31'd0, ex_reg_we}, 32'd1);

    // ---------------- load-use hazard ----------------
    instruction_in = mk(OP_LOAD, 3'd4, 3'd1, 3'd0, 16'h0008);
    rs1_data = 32'h1000;
    tick();
    check("load_mem_re", {31'd0, ex_mem_re}, 32'd1);
    check("load_op_b", ex_op_b, 32'd8);
    // ALU-imm whose unused rs2 field matches the load rd: no hazard
    instruction_in = mk(7'b0100000, 3'd6, 3'd1, 3'd4, 16'h0001);
    #1;
    check("lu_unused_rs2_hold", {31'd0, hold_out}, 32'd0);
    // ALU-reg reading the load destination through rs1
    instruction_in = mk(7'b0000000, 3'd5, 3'd4, 3'd6, 16'h0000);
    rs1_data = 32'd7;
    rs2_data = 32'd9;
    #1;
    check("lu_hold", {31'd0, hold_out}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_opcode", {25'd0, ex_opcode}, 32'h64);
    check("lu_bubble_we", {29'd0, ex_reg_we, ex_mem_re, ex_mem_we}, 32'd0);
    check("lu_hold_released", {31'd0, hold_out}, 32'd0);
    tick();
    check("lu_alu_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_alu_rd", {29'd0, ex_rd}, 32'd5);
    check("lu_alu_ops", ex_op_a + (ex_op_b << 8), 32'd7 + (32'd9 << 8));

    // ---------------- flag hazard then BCOND EQ ----------------
    instruction_in = mk(7'b0010000, 3'd1, 3'd2, 3'd3, 16'h0000);
    tick();
    check("flagop_set_flags", {31'd0, ex_set_flags}, 32'd1);
    instruction_in = mk(OP_BCOND, 3'b000, 3'd0, 3'd0, 16'h0010);
    pc_in    = 32'h100;
    flags_in = 4'b0100;
    #1;
    check("fh_hold", {31'd0, hold_out}, 32'd1);
    check("fh_no_branch", {31'd0, branch}, 32'd0);
    tick();
    check("fh_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("beq_branch", {31'd0, branch}, 32'd1);
    check("beq_target", cond_pc_val, 32'h110);
    check("beq_hold", {31'd0, hold_out}, 32'd0);
    tick();
    check("beq_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("beq_ex_opcode", {25'd0, ex_opcode}, 32'h61);
    check("beq_ex_we", {29'd0, ex_reg_we, ex_mem_re, ex_mem_we}, 32'd0);

    // ---------------- BCOND NE / AL with wrap ----------------
    instruction_in = mk(OP_BCOND, 3'b001, 3'd0, 3'd0, 16'h0010);
    #1;
    check("bne_not_taken", {31'd0, branch}, 32'd0);
    instruction_in = mk(OP_BCOND, 3'b111, 3'd0, 3'd0, 16'hFFF4);
    pc_in = 32'h8;
    #1;
    check("bal_taken", {31'd0, branch}, 32'd1);
    check("bal_wrap_target", cond_pc_val, 32'hFFFFFFFC);

    // ---------------- stall during BCOND AL ----------------
    instruction_in = mk(7'b0100000, 3'd2, 3'd0, 3'd0, 16'h0005);
    rs1_data = 32'd3;
    tick();
    instruction_in = mk(OP_BCOND, 3'b111, 3'd0, 3'd0, 16'hFFF4);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_no_branch", {31'd0, branch}, 32'd0);
      check("stall_hold", {31'd0, hold_out}, 32'd1);
      tick();
      check("stall_ex_held", {ex_opcode, ex_rd, ex_op_b[21:0]}, {7'h20, 3'd2, 22'd5});
    end
    stall_in = 1'b0;
    #1;
    check("stall_release_branch", {31'd0, branch}, 32'd1);
    check("stall_release_hold", {31'd0, hold_out}, 32'd0);
    tick();
    check("stall_release_ex", {25'd0, ex_opcode}, 32'h61);

    // ---------------- stall and load-use together ----------------
    instruction_in = mk(OP_LOAD, 3'd4, 3'd1, 3'd0, 16'h0000);
    tick();
    stall_in = 1'b1;
    instruction_in = mk(7'b0000000, 3'd5, 3'd7, 3'd4, 16'h0000);
    tick();
    check("stall_wins_opcode", {25'd0, ex_opcode}, 32'h40);
    check("stall_wins_valid", {31'd0, ex_valid}, 32'd1);
    stall_in = 1'b0;
    #1;
    check("hazard_reeval_hold", {31'd0, hold_out}, 32'd1);
    tick();
    check("hazard_reeval_bubble", {31'd0, ex_valid}, 32'd0);
    tick();
    check("hazard_reeval_issue", {29'd0, ex_rd}, 32'd5);

    // ---------------- asynchronous reset mid-stream ----------------
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    check("async_rst_opcode", {25'd0, ex_opcode}, 32'h64);
    #3;
    check("rst_held_valid", {31'd0, ex_valid}, 32'd0);
    instruction_in = mk(7'b0000000, 3'd1, 3'd6, 3'd5, 16'h0000);
    reset = 1'b1;
    #1;
    check("post_rst_addrs", {26'd0, rs1_addr, rs2_addr}, {26'd0, 3'd6, 3'd5});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_id_stage
`default_nettype wire
